// File: rtl/clock_divider_multi_pkg.sv
// Shared constants for the multi-channel clock divider.
package clock_divider_multi_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/clock_divider_chan.sv
// One divider channel: counter, active and shadow divisor/mode, pending flag, registered out/wrap.
module clock_divider_chan
  import clock_divider_multi_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH  = 24,
  parameter int unsigned DEFAULT_DIV  = 6000000,
  parameter bit          DEFAULT_MODE = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   sync_i,
  input  logic                   load_i,
  input  logic [COUNT_WIDTH-1:0] ld_div_i,
  input  logic                   ld_mode_i,
  output logic                   out_o,
  output logic                   wrap_o,
  output logic                   pending_o
);

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] div_q, div_d;
  logic [COUNT_WIDTH-1:0] sh_div_q, sh_div_d;
  logic                   mode_q, mode_d;
  logic                   sh_mode_q, sh_mode_d;
  logic                   pend_q, pend_d;
  logic                   out_q, out_d;
  logic                   wrap_q, wrap_d;
  logic                   running, at_end, wrap_ev, apply;

  always_comb begin
    running = en_i && (div_q != '0);
    at_end  = running && (cnt_q == div_q - COUNT_WIDTH'(1));
    wrap_ev = at_end && !sync_i;
    apply   = pend_q && (wrap_ev || sync_i || !running);

    cnt_d     = cnt_q;
    out_d     = out_q;
    wrap_d    = 1'b0;
    div_d     = div_q;
    mode_d    = mode_q;
    sh_div_d  = sh_div_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;

    if (sync_i) begin
      cnt_d = '0;
    end else if (running) begin
      if (at_end) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
        out_d  = (mode_q == MODE_TOGGLE) ? ~out_q : 1'b1;
      end else begin
        cnt_d = cnt_q + COUNT_WIDTH'(1);
        if (mode_q == MODE_PULSE) out_d = 1'b0;
      end
    end

    // Apply overrides the counter; the old period's final toggle stands unless the mode changes.
    if (apply) begin
      div_d  = sh_div_q;
      mode_d = sh_mode_q;
      pend_d = 1'b0;
      cnt_d  = '0;
      if (sh_mode_q != mode_q) out_d = 1'b0;
    end

    // A load can only be accepted while not pending, so it never coincides with apply.
    if (load_i) begin
      sh_div_d  = ld_div_i;
      sh_mode_d = ld_mode_i;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      div_q     <= COUNT_WIDTH'(DEFAULT_DIV);
      mode_q    <= DEFAULT_MODE;
      sh_div_q  <= COUNT_WIDTH'(DEFAULT_DIV);
      sh_mode_q <= DEFAULT_MODE;
      pend_q    <= 1'b0;
      out_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      sh_div_q  <= sh_div_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      wrap_q    <= wrap_d;
    end
  end

  assign out_o     = out_q;
  assign wrap_o    = wrap_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with a valid/ready divisor/mode config port.
module clock_divider_multi
  import clock_divider_multi_pkg::*;
#(
  parameter int unsigned NUM_CHAN     = 4,
  parameter int unsigned COUNT_WIDTH  = 24,
  parameter int unsigned CHAN_W       = 2,
  parameter int unsigned DEFAULT_DIV  = 6000000,
  parameter bit          DEFAULT_MODE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CHAN-1:0]    en,
  input  logic                   sync,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CHAN_W-1:0]      cfg_chan,
  input  logic [COUNT_WIDTH-1:0] cfg_div,
  input  logic                   cfg_mode,
  output logic [NUM_CHAN-1:0]    out,
  output logic [NUM_CHAN-1:0]    wrap,
  output logic [NUM_CHAN-1:0]    pending
);

  logic [NUM_CHAN-1:0] load;

  // Out-of-range channels never match, so such writes are always accepted and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      if ((cfg_chan == CHAN_W'(i)) && pending[i]) cfg_ready = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
    assign load[i] = cfg_valid && cfg_ready && (cfg_chan == CHAN_W'(i));

    clock_divider_chan #(
      .COUNT_WIDTH  (COUNT_WIDTH),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_MODE (DEFAULT_MODE)
    ) u_chan (
      .clk_i     (clk),
      .rst_ni    (rst),
      .en_i      (en[i]),
      .sync_i    (sync),
      .load_i    (load[i]),
      .ld_div_i  (cfg_div),
      .ld_mode_i (cfg_mode),
      .out_o     (out[i]),
      .wrap_o    (wrap[i]),
      .pending_o (pending[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: vector table, directed corner sequences, random run vs model.
module tb_clock_divider_multi;

  localparam int NC   = 4;
  localparam int CW   = 8;
  localparam int CHW  = 3;
  localparam int DDIV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sync = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_mode = 1'b0;
  logic          cfg_ready;
  logic [NC-1:0] en = '0;
  logic [NC-1:0] out, wrap, pending;
  logic [CHW-1:0] cfg_chan = '0;
  logic [CW-1:0]  cfg_div = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: period position, active/shadow settings, observable outputs.
  int unsigned m_cnt[NC], m_div[NC], m_sdiv[NC];
  bit          m_mode[NC], m_smode[NC], m_pend[NC], m_out[NC], m_wrap[NC];

  always #5 clk = ~clk;

  clock_divider_multi #(
    .NUM_CHAN     (NC),
    .COUNT_WIDTH  (CW),
    .CHAN_W       (CHW),
    .DEFAULT_DIV  (DDIV),
    .DEFAULT_MODE (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .out       (out),
    .wrap      (wrap),
    .pending   (pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    if (int'(cfg_chan) < NC) return !m_pend[cfg_chan[1:0]];
    return 1'b1;
  endfunction

  function automatic logic [NC-1:0] pack(input int sel);
    logic [NC-1:0] r;
    for (int c = 0; c < NC; c++)
      r[c] = (sel == 0) ? m_out[c] : (sel == 1) ? m_wrap[c] : m_pend[c];
    return r;
  endfunction

  task automatic model_step();
    bit acc;
    acc = cfg_valid && m_ready();
    for (int c = 0; c < NC; c++) begin
      bit run, last, wr, app;
      if (!rst) begin
        m_cnt[c] = 0; m_div[c] = DDIV; m_sdiv[c] = DDIV;
        m_mode[c] = 0; m_smode[c] = 0; m_pend[c] = 0; m_out[c] = 0; m_wrap[c] = 0;
        continue;
      end
      run  = en[c] && (m_div[c] != 0);
      last = run && (m_cnt[c] + 1 == m_div[c]);
      wr   = last && !sync;
      app  = m_pend[c] && (wr || sync || !run);
      m_wrap[c] = wr;
      if (run && !sync) m_out[c] = m_mode[c] ? wr : (m_out[c] ^ wr);
      if (sync || wr) m_cnt[c] = 0;
      else if (run) m_cnt[c] = m_cnt[c] + 1;
      if (app) begin
        if (m_smode[c] != m_mode[c]) m_out[c] = 0;
        m_div[c] = m_sdiv[c]; m_mode[c] = m_smode[c]; m_pend[c] = 0; m_cnt[c] = 0;
      end
      if (acc && (int'(cfg_chan) == c)) begin
        m_sdiv[c] = cfg_div; m_smode[c] = cfg_mode; m_pend[c] = 1;
      end
    end
  endtask

  // One clock: check ready before the edge, advance model, check registered outputs after.
  task automatic cycle();
    #1;
    check("cfg_ready", cfg_ready, m_ready());
    model_step();
    @(posedge clk);
    #1;
    check("out", out, pack(0));
    check("wrap", wrap, pack(1));
    check("pending", pending, pack(2));
  endtask

  task automatic do_reset();
    rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0; en = '1;
    cycle();
    rst = 1'b1;
  endtask

  task automatic cfg(input logic [CHW-1:0] ch, input logic [CW-1:0] d, input logic m);
    cfg_valid = 1'b1; cfg_chan = ch; cfg_div = d; cfg_mode = m;
  endtask

  typedef struct {
    logic [NC-1:0] en;
    logic          sync;
    logic [NC-1:0] exp_out;
    logic [NC-1:0] exp_wrap;
  } vec_t;

  vec_t tbl[10];
  logic [5:0] seq;
  logic       acc_bits;

  initial begin
    tbl[0] = '{4'hF, 1'b0, 4'h0, 4'h0};
    tbl[1] = '{4'hF, 1'b0, 4'h0, 4'h0};
    tbl[2] = '{4'hF, 1'b0, 4'h0, 4'h0};
    tbl[3] = '{4'hF, 1'b0, 4'hF, 4'hF};
    tbl[4] = '{4'hF, 1'b0, 4'hF, 4'h0};
    tbl[5] = '{4'hF, 1'b0, 4'hF, 4'h0};
    tbl[6] = '{4'hF, 1'b0, 4'hF, 4'h0};
    tbl[7] = '{4'hF, 1'b0, 4'h0, 4'hF};
    tbl[8] = '{4'h0, 1'b0, 4'h0, 4'h0};
    tbl[9] = '{4'h0, 1'b0, 4'h0, 4'h0};

    // Reset state and default divide-by-4 toggle.
    do_reset();
    check("reset_out", out, 4'h0);
    check("reset_wrap", wrap, 4'h0);
    check("reset_pending", pending, 4'h0);
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en; sync = tbl[i].sync;
      cycle();
      check($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
      check($sformatf("tbl%0d_wrap", i), wrap, tbl[i].exp_wrap);
    end

    // Reconfigure ch1 to pulse D=3 while running D=4.
    do_reset();
    cycle();
    cfg(3'd1, 8'd3, 1'b1);
    cycle();
    cfg_valid = 1'b0;
    check("t2_pending_set", pending, 4'b0010);
    cycle();
    cycle();
    check("t2_wrap1", wrap[1], 1'b1);
    check("t2_out1_suppressed", out[1], 1'b0);
    check("t2_pending_clr", pending[1], 1'b0);
    for (int i = 5; i >= 0; i--) begin
      cycle();
      seq[i] = out[1];
    end
    check("t2_pulse_seq", seq, 6'b001001);

    // Second write while pending is held off until after the apply.
    do_reset();
    cfg(3'd1, 8'd3, 1'b1);
    cycle();
    cfg(3'd1, 8'd5, 1'b0);
    #1;
    check("t3_ready_low", cfg_ready, 1'b0);
    cycle();
    cycle();
    cycle();
    check("t3_ready_after_apply", cfg_ready, 1'b1);
    cycle();
    cfg_valid = 1'b0;
    check("t3_second_pending", pending[1], 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    check("t3_second_applied", pending[1], 1'b0);

    // Sync coinciding with ch0 wrap: no toggle, no wrap, channels realigned.
    do_reset();
    en = 4'b0001;
    cycle(); cycle();
    en = 4'hF;
    cycle();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    check("t4_sync_wrap", wrap, 4'h0);
    check("t4_sync_out", out, 4'h0);
    for (int i = 0; i < 4; i++) cycle();
    check("t4_aligned_wrap", wrap, 4'hF);

    // Disabled channel takes D=0 at once, stays frozen, then restarts with D=2.
    do_reset();
    en = 4'b1011;
    cfg(3'd2, 8'd0, 1'b0);
    cycle();
    cfg_valid = 1'b0;
    check("t5_pending_set", pending[2], 1'b1);
    cycle();
    check("t5_applied", pending[2], 1'b0);
    en = 4'hF;
    acc_bits = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      acc_bits = acc_bits | wrap[2] | out[2];
    end
    check("t5_frozen", acc_bits, 1'b0);
    cfg(3'd2, 8'd2, 1'b0);
    cycle();
    cfg_valid = 1'b0;
    cycle();
    check("t5_d2_applied", pending[2], 1'b0);
    for (int i = 3; i >= 0; i--) begin
      cycle();
      seq[i] = out[2];
    end
    check("t5_toggle_seq", seq[3:0], 4'b0110);

    // Mid-run reset with pending shadow and an in-flight write; then out-of-range write.
    do_reset();
    cycle(); cycle();
    cfg(3'd0, 8'd7, 1'b0);
    cycle();
    check("t6_pending_before", pending[0], 1'b1);
    cfg(3'd3, 8'd2, 1'b1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check("t6_rst_out", out, 4'h0);
    check("t6_rst_wrap", wrap, 4'h0);
    check("t6_rst_pending", pending, 4'h0);
    cfg(3'd7, 8'd1, 1'b1);
    #1;
    check("t6_ready_oor", cfg_ready, 1'b1);
    cycle();
    cfg_valid = 1'b0;
    check("t6_oor_no_pending", pending, 4'h0);
    cycle(); cycle(); cycle();
    check("t6_default_wrap", wrap, 4'hF);
    check("t6_default_out", out, 4'hF);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) != 0);
      sync      = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < NC; c++) en[c] = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 9) < 3);
      cfg_chan  = CHW'($urandom_range(0, 7));
      cfg_div   = CW'($urandom_range(0, 6));
      cfg_mode  = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
